// File: rtl/node_pos_collector.sv
// node_pos_collector: captures node x/y on one-hot strobes into a FWFT FIFO; `define COLLECTOR_SWEEP_TAG_EN adds out_sweep.
module node_pos_collector #(
  parameter int NODE_COUNT    = 5,
  parameter int FIFO_DEPTH    = 8,
  parameter int CAPTURE_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NODE_COUNT-1:0]         verlet_state,
  input  logic [32*NODE_COUNT-1:0]      x_pos_flat,
  input  logic [32*NODE_COUNT-1:0]      y_pos_flat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_node_id,
  output logic [31:0]                   out_x,
  output logic [31:0]                   out_y,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          strobe_error
`ifdef COLLECTOR_SWEEP_TAG_EN
  ,
  output logic [15:0]                   out_sweep
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [NODE_COUNT-1:0] prev_state, fresh;
  logic one_hot, multi;
  logic [7:0] ev_id;
  logic [CAPTURE_DELAY-1:0] stg_v;
  logic [7:0] stg_id [CAPTURE_DELAY];
  logic [31:0] sx, sy;
  logic [7:0] mem_id [FIFO_DEPTH];
  logic [31:0] mem_x [FIFO_DEPTH];
  logic [31:0] mem_y [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, full, accept;
`ifdef COLLECTOR_SWEEP_TAG_EN
  logic [15:0] sweep;
  logic [15:0] mem_s [FIFO_DEPTH];
`endif
  assign fresh = verlet_state & ~prev_state;
  assign one_hot = fresh != '0 && (fresh & (fresh - NODE_COUNT'(1))) == '0;
  assign multi = fresh != '0 && !one_hot;
  assign push = stg_v[CAPTURE_DELAY-1];
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  // a full FIFO still takes a push when the head leaves on the same edge
  assign accept = push && (!full || pop);
  assign fifo_level = count;
  assign out_node_id = out_valid ? mem_id[rd_ptr] : '0;
  assign out_x = out_valid ? mem_x[rd_ptr] : '0;
  assign out_y = out_valid ? mem_y[rd_ptr] : '0;
  assign out_last = out_valid && out_node_id == 8'(NODE_COUNT-1);
`ifdef COLLECTOR_SWEEP_TAG_EN
  assign out_sweep = out_valid ? mem_s[rd_ptr] : '0;
`endif
  always_comb begin
    ev_id = '0;
    sx = '0;
    sy = '0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      ev_id = fresh[i] ? 8'(i) : ev_id;
      sx = stg_id[CAPTURE_DELAY-1] == 8'(i) ? x_pos_flat[32*i +: 32] : sx;
      sy = stg_id[CAPTURE_DELAY-1] == 8'(i) ? y_pos_flat[32*i +: 32] : sy;
    end
  end
  always_ff @(posedge clk) begin
    stg_id[0] <= ev_id;
    for (int i = CAPTURE_DELAY-1; i > 0; i--) stg_id[i] <= stg_id[i-1];
    if (accept) begin
      mem_id[wr_ptr] <= stg_id[CAPTURE_DELAY-1];
      mem_x[wr_ptr] <= sx;
      mem_y[wr_ptr] <= sy;
`ifdef COLLECTOR_SWEEP_TAG_EN
      mem_s[wr_ptr] <= sweep;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state <= '0;
      stg_v <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      strobe_error <= 1'b0;
`ifdef COLLECTOR_SWEEP_TAG_EN
      sweep <= '0;
`endif
    end else begin
      prev_state <= verlet_state;
      stg_v[0] <= one_hot;
      for (int i = CAPTURE_DELAY-1; i > 0; i--) stg_v[i] <= stg_v[i-1];
      if (multi) strobe_error <= 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
`ifdef COLLECTOR_SWEEP_TAG_EN
      if (accept && stg_id[CAPTURE_DELAY-1] == 8'(NODE_COUNT-1)) sweep <= sweep + 16'd1;
`endif
    end
  end
endmodule

// File: tb/tb_node_pos_collector.sv
// tb_node_pos_collector: directed table plus corner-case sequences for node_pos_collector.
module tb_node_pos_collector;
  logic clk = 1'b0, reset = 1'b1, out_ready = 1'b0;
  logic [4:0] verlet_state = '0;
  logic [159:0] x_pos_flat, y_pos_flat;
  logic out_valid, out_last, overflow, strobe_error;
  logic [7:0] out_node_id;
  logic [31:0] out_x, out_y;
  logic [3:0] fifo_level;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [4:0] vs;
    logic rdy;
    logic ev;
    logic [7:0] id;
    logic last;
    logic [3:0] lvl;
  } vec_t;
  vec_t vec [18];
  node_pos_collector #(.NODE_COUNT(5), .FIFO_DEPTH(8), .CAPTURE_DELAY(1)) dut (
    .clk(clk), .reset(reset), .verlet_state(verlet_state),
    .x_pos_flat(x_pos_flat), .y_pos_flat(y_pos_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_node_id(out_node_id),
    .out_x(out_x), .out_y(out_y), .out_last(out_last), .fifo_level(fifo_level),
    .overflow(overflow), .strobe_error(strobe_error)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_head(input string nm, input int id);
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " id"}, 32'(out_node_id), 32'(id));
    chk({nm, " x"}, out_x, 32'(id * 256));
    chk({nm, " y"}, out_y, 32'h200 + 32'(id));
  endtask
  task automatic do_reset;
    reset = 1'b1;
    verlet_state = '0;
    out_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      x_pos_flat[32*i +: 32] = 32'(i * 256);
      y_pos_flat[32*i +: 32] = 32'h200 + 32'(i);
    end
    vec = '{
      '{5'd1,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd2,  1'b1, 1'b1, 8'd0, 1'b0, 4'd1},
      '{5'd4,  1'b1, 1'b1, 8'd1, 1'b0, 4'd1},
      '{5'd8,  1'b1, 1'b1, 8'd2, 1'b0, 4'd1},
      '{5'd16, 1'b1, 1'b1, 8'd3, 1'b0, 4'd1},
      '{5'd0,  1'b1, 1'b1, 8'd4, 1'b1, 4'd1},
      '{5'd0,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b1, 8'd2, 1'b0, 4'd1},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd4,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0},
      '{5'd0,  1'b1, 1'b0, 8'd0, 1'b0, 4'd0}
    };
    tick;
    tick;
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst level", 32'(fifo_level), 32'd0);
    chk("rst ovf", 32'(overflow), 32'd0);
    chk("rst err", 32'(strobe_error), 32'd0);
    chk("rst id", 32'(out_node_id), 32'd0);
    chk("rst x", out_x, 32'd0);
    chk("rst y", out_y, 32'd0);
    chk("rst last", 32'(out_last), 32'd0);
    reset = 1'b0;
    // sweep 0..4 then a 10-cycle held strobe
    for (int r = 0; r < 18; r++) begin
      verlet_state = vec[r].vs;
      out_ready = vec[r].rdy;
      tick;
      chk($sformatf("row%0d valid", r), 32'(out_valid), 32'(vec[r].ev));
      chk($sformatf("row%0d level", r), 32'(fifo_level), 32'(vec[r].lvl));
      chk($sformatf("row%0d last", r), 32'(out_last), 32'(vec[r].last));
      if (vec[r].ev) chk_head($sformatf("row%0d", r), int'(vec[r].id));
    end
    // multi-bit strobe
    do_reset;
    out_ready = 1'b1;
    tick;
    verlet_state = 5'd6;
    tick;
    chk("multi err", 32'(strobe_error), 32'd1);
    tick;
    chk("multi valid", 32'(out_valid), 32'd0);
    chk("multi level", 32'(fifo_level), 32'd0);
    verlet_state = 5'd0;
    tick;
    verlet_state = 5'd1;
    tick;
    tick;
    chk_head("after multi", 0);
    chk("err sticky", 32'(strobe_error), 32'd1);
    tick;
    // overflow: 10 events into 8 slots
    do_reset;
    for (int k = 0; k < 10; k++) begin
      verlet_state = 5'(1 << (k % 5));
      tick;
    end
    verlet_state = 5'd0;
    tick;
    tick;
    chk("ovf level", 32'(fifo_level), 32'd8);
    chk("ovf flag", 32'(overflow), 32'd1);
    chk_head("ovf stall head", 0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("ovf drain%0d", k), k % 5);
      tick;
    end
    chk("ovf empty", 32'(out_valid), 32'd0);
    chk("ovf empty level", 32'(fifo_level), 32'd0);
    chk("ovf sticky", 32'(overflow), 32'd1);
    // push and pop together while full
    do_reset;
    for (int k = 0; k < 8; k++) begin
      verlet_state = 5'(1 << (k % 5));
      tick;
    end
    verlet_state = 5'd8;
    tick;
    chk("full level", 32'(fifo_level), 32'd8);
    verlet_state = 5'd0;
    out_ready = 1'b1;
    tick;
    chk("pp level", 32'(fifo_level), 32'd8);
    chk("pp ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("pp drain%0d", k), (k + 1) % 5);
      tick;
    end
    chk("pp empty", 32'(out_valid), 32'd0);
    // reset mid-operation
    do_reset;
    verlet_state = 5'd24;
    tick;
    verlet_state = 5'd0;
    tick;
    for (int k = 0; k < 4; k++) begin
      verlet_state = 5'(1 << k);
      tick;
    end
    chk("mid level", 32'(fifo_level), 32'd3);
    chk("mid err", 32'(strobe_error), 32'd1);
    reset = 1'b1;
    verlet_state = 5'd0;
    tick;
    chk("mid rst valid", 32'(out_valid), 32'd0);
    chk("mid rst level", 32'(fifo_level), 32'd0);
    chk("mid rst err", 32'(strobe_error), 32'd0);
    chk("mid rst ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("no ghost%0d", k), 32'(out_valid), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
